// File: rtl/stage_mem.sv
// Memory stage: single-cycle scalar load/store plus 4-beat 128-bit matrix load/store
// over a 32-bit word-addressed data memory port.
module stage_mem #(
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_valid,
  input  logic [31:0]        mem_alu_o,
  input  logic [31:0]        mem_rs2_data,
  input  logic [127:0]       mem_matrix_i,
  input  logic               mem_mem_read,
  input  logic               mem_mem_write,
  input  logic               mem_mat_load,
  input  logic               mem_mat_store,
  input  logic               mem_mem2reg,
  input  logic               mem_reg_write,
  input  logic [4:0]         mem_rd,
  output logic               mem_stall,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               dmem_we,
  input  logic [31:0]        dmem_rdata,
  output logic [31:0]        wb_mem_data,
  output logic [31:0]        wb_alu_o,
  output logic [127:0]       wb_matrix_o,
  output logic               wb_mem2reg,
  output logic               wb_reg_write,
  output logic [4:0]         wb_rd,
  output logic               wb_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MLD  = 2'd1,
    MST  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [DMEM_AW-1:0]   base_q, base_d;
  logic [127:0]         buf_q, buf_d;
  logic [4:0]           rd_q, rd_d;
  logic                 mem2reg_q, mem2reg_d;
  logic                 reg_write_q, reg_write_d;
  logic [31:0]          alu_q, alu_d;

  logic [31:0]          wb_mem_data_q, wb_mem_data_d;
  logic [31:0]          wb_alu_q, wb_alu_d;
  logic [127:0]         wb_matrix_q, wb_matrix_d;
  logic                 wb_mem2reg_q, wb_mem2reg_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic                 wb_valid_q, wb_valid_d;

  logic                 stall_s;
  logic                 we_s;
  logic [DMEM_AW-1:0]   addr_s;
  logic [31:0]          wdata_s;
  logic                 unused_s;

  // Read-enable carries no information: the memory port reads combinationally every cycle.
  assign unused_s = mem_mem_read;

  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = v[31:0];
      2'd1:    w = v[63:32];
      2'd2:    w = v[95:64];
      default: w = v[127:96];
    endcase
    return w;
  endfunction

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    base_d         = base_q;
    buf_d          = buf_q;
    rd_d           = rd_q;
    mem2reg_d      = mem2reg_q;
    reg_write_d    = reg_write_q;
    alu_d          = alu_q;
    wb_mem_data_d  = wb_mem_data_q;
    wb_alu_d       = wb_alu_q;
    wb_matrix_d    = wb_matrix_q;
    wb_mem2reg_d   = wb_mem2reg_q;
    wb_rd_d        = wb_rd_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    stall_s        = 1'b0;
    we_s           = 1'b0;
    addr_s         = mem_alu_o[DMEM_AW+1:2];
    wdata_s        = mem_rs2_data;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (mem_mat_store || mem_mat_load) begin
            stall_s     = 1'b1;
            base_d      = mem_alu_o[DMEM_AW+1:2];
            rd_d        = mem_rd;
            mem2reg_d   = mem_mem2reg;
            reg_write_d = mem_reg_write;
            alu_d       = mem_alu_o;
            beat_d      = 2'd1;
            // Store has priority over load when both flags are set.
            if (mem_mat_store) begin
              we_s    = 1'b1;
              wdata_s = mem_matrix_i[31:0];
              buf_d   = mem_matrix_i;
              state_d = MST;
            end else begin
              buf_d   = {96'd0, dmem_rdata};
              state_d = MLD;
            end
          end else begin
            we_s           = mem_mem_write;
            wb_mem_data_d  = dmem_rdata;
            wb_alu_d       = mem_alu_o;
            wb_matrix_d    = mem_matrix_i;
            wb_mem2reg_d   = mem_mem2reg;
            wb_reg_write_d = mem_reg_write;
            wb_rd_d        = mem_rd;
            wb_valid_d     = 1'b1;
          end
        end else begin
          we_s = 1'b0;
        end
      end
      MLD: begin
        addr_s  = base_q + DMEM_AW'(beat_q);
        stall_s = (beat_q != 2'd3);
        case (beat_q)
          2'd1:    buf_d[63:32]  = dmem_rdata;
          2'd2:    buf_d[95:64]  = dmem_rdata;
          default: buf_d[127:96] = dmem_rdata;
        endcase
        if (beat_q == 2'd3) begin
          wb_matrix_d    = {dmem_rdata, buf_q[95:0]};
          wb_mem_data_d  = dmem_rdata;
          wb_alu_d       = alu_q;
          wb_mem2reg_d   = mem2reg_q;
          wb_reg_write_d = reg_write_q;
          wb_rd_d        = rd_q;
          wb_valid_d     = 1'b1;
          beat_d         = 2'd0;
          state_d        = IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      MST: begin
        addr_s  = base_q + DMEM_AW'(beat_q);
        we_s    = 1'b1;
        wdata_s = word_sel(buf_q, beat_q);
        stall_s = (beat_q != 2'd3);
        if (beat_q == 2'd3) begin
          wb_alu_d       = alu_q;
          wb_mem2reg_d   = 1'b0;
          wb_rd_d        = rd_q;
          wb_valid_d     = 1'b1;
          beat_d         = 2'd0;
          state_d        = IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  // Port strobes are gated by reset so a mid-burst abort stops writes immediately.
  assign mem_stall  = rst_n & stall_s;
  assign dmem_we    = rst_n & we_s;
  assign dmem_addr  = addr_s;
  assign dmem_wdata = wdata_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      base_q         <= '0;
      buf_q          <= 128'd0;
      rd_q           <= 5'd0;
      mem2reg_q      <= 1'b0;
      reg_write_q    <= 1'b0;
      alu_q          <= 32'd0;
      wb_mem_data_q  <= 32'd0;
      wb_alu_q       <= 32'd0;
      wb_matrix_q    <= 128'd0;
      wb_mem2reg_q   <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      base_q         <= base_d;
      buf_q          <= buf_d;
      rd_q           <= rd_d;
      mem2reg_q      <= mem2reg_d;
      reg_write_q    <= reg_write_d;
      alu_q          <= alu_d;
      wb_mem_data_q  <= wb_mem_data_d;
      wb_alu_q       <= wb_alu_d;
      wb_matrix_q    <= wb_matrix_d;
      wb_mem2reg_q   <= wb_mem2reg_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_valid_q     <= wb_valid_d;
    end
  end

  assign wb_mem_data  = wb_mem_data_q;
  assign wb_alu_o     = wb_alu_q;
  assign wb_matrix_o  = wb_matrix_q;
  assign wb_mem2reg   = wb_mem2reg_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_valid     = wb_valid_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: table of scalar vectors plus hand-written
// matrix load/store, back-to-back and mid-burst reset sequences.
module tb_stage_mem;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_valid, mem_mem_read, mem_mem_write, mem_mat_load, mem_mat_store;
  logic         mem_mem2reg, mem_reg_write;
  logic [31:0]  mem_alu_o, mem_rs2_data;
  logic [127:0] mem_matrix_i;
  logic [4:0]   mem_rd;
  logic         mem_stall, dmem_we;
  logic [9:0]   dmem_addr;
  logic [31:0]  dmem_wdata, dmem_rdata;
  logic [31:0]  wb_mem_data, wb_alu_o;
  logic [127:0] wb_matrix_o;
  logic         wb_mem2reg, wb_reg_write, wb_valid;
  logic [4:0]   wb_rd;

  bit   [31:0]  mem [0:1023];
  logic         pl_we = 1'b0;
  logic [9:0]   pl_addr = 10'd0;
  logic [31:0]  pl_data = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stage_mem #(.DMEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_alu_o(mem_alu_o),
    .mem_rs2_data(mem_rs2_data), .mem_matrix_i(mem_matrix_i),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mat_load(mem_mat_load), .mem_mat_store(mem_mat_store),
    .mem_mem2reg(mem_mem2reg), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_stall(mem_stall), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .wb_mem_data(wb_mem_data),
    .wb_alu_o(wb_alu_o), .wb_matrix_o(wb_matrix_o), .wb_mem2reg(wb_mem2reg),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_valid(wb_valid)
  );

  assign dmem_rdata = mem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  typedef struct {
    logic        valid, rd_en, wr_en, m2r, rw;
    logic [4:0]  rd;
    logic [31:0] alu, rs2;
    logic [9:0]  e_addr;
    logic        e_we, e_valid, e_rw;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic [31:0] e_alu;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic clear_inputs();
    mem_valid = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    mem_mat_load = 1'b0; mem_mat_store = 1'b0; mem_mem2reg = 1'b0;
    mem_reg_write = 1'b0; mem_alu_o = 32'd0; mem_rs2_data = 32'd0;
    mem_matrix_i = 128'd0; mem_rd = 5'd0;
  endtask

  initial begin
    logic [127:0] pat;
    logic [127:0] exp_mat;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0040, 32'h0, 10'h010, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd5, 32'h0000_0040};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0084, 32'hCAFEF00D, 10'h021, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 32'h0000_0084};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0087, 32'h0, 10'h021, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 5'd9, 32'h0000_0087};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_0080, 32'h12345678, 10'h020, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 5'd9, 32'h0000_0087};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'h0, 10'h08D, 1'b0, 1'b1, 1'b1, 32'h0, 5'd3, 32'h0000_1234};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0, 10'h3FF, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 5'd31, 32'hFFFF_FFFC};

    // Asynchronous reset with aggressive inputs applied
    clear_inputs();
    rst_n = 1'b1;
    #2;
    mem_valid = 1'b1; mem_mem_write = 1'b1; mem_mat_load = 1'b1; mem_mat_store = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall", mem_stall, 128'd0);
    chk("rst_we", dmem_we, 128'd0);
    chk("rst_wb_valid", wb_valid, 128'd0);
    chk("rst_wb_rw", wb_reg_write, 128'd0);
    chk("rst_wb_matrix", wb_matrix_o, 128'd0);
    chk("rst_wb_data", wb_mem_data, 128'd0);
    clear_inputs();

    preload(10'h010, 32'hDEADBEEF);
    preload(10'h3FF, 32'h55AA55AA);
    preload(10'h040, 32'h11);
    preload(10'h041, 32'h22);
    preload(10'h042, 32'h33);
    preload(10'h043, 32'h44);
    for (int i = 0; i < 4; i++) preload(10'h0C0 + 10'(i), 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Scalar vector table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      mem_valid = vecs[i].valid; mem_mem_read = vecs[i].rd_en; mem_mem_write = vecs[i].wr_en;
      mem_mem2reg = vecs[i].m2r; mem_reg_write = vecs[i].rw; mem_rd = vecs[i].rd;
      mem_alu_o = vecs[i].alu; mem_rs2_data = vecs[i].rs2;
      #1;
      chk($sformatf("vec%0d_stall", i), mem_stall, 128'd0);
      chk($sformatf("vec%0d_addr", i), dmem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_we", i), dmem_we, vecs[i].e_we);
      if (vecs[i].e_we) chk($sformatf("vec%0d_wdata", i), dmem_wdata, vecs[i].rs2);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_wb_rw", i), wb_reg_write, vecs[i].e_rw);
      chk($sformatf("vec%0d_wb_data", i), wb_mem_data, vecs[i].e_data);
      chk($sformatf("vec%0d_wb_rd", i), wb_rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_wb_alu", i), wb_alu_o, vecs[i].e_alu);
    end

    // Matrix load at 0x100, then back-to-back scalar add; inputs are junk during beats
    @(negedge clk);
    clear_inputs();
    mem_valid = 1'b1; mem_mat_load = 1'b1; mem_alu_o = 32'h100; mem_rd = 5'd4; mem_reg_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        mem_alu_o = 32'h300; mem_rd = 5'd1; mem_mat_store = 1'b1; mem_mat_load = 1'b0;
        mem_mem_write = 1'b1; mem_matrix_i = {4{32'hBAD0BAD0}};
      end
      #1;
      chk($sformatf("mld%0d_stall", k), mem_stall, (k < 3) ? 128'd1 : 128'd0);
      chk($sformatf("mld%0d_addr", k), dmem_addr, 128'h40 + 128'(k));
      chk($sformatf("mld%0d_we", k), dmem_we, 128'd0);
      @(posedge clk); #1;
      chk($sformatf("mld%0d_wb_valid", k), wb_valid, (k == 3) ? 128'd1 : 128'd0);
      if (k < 3) chk($sformatf("mld%0d_wb_rw", k), wb_reg_write, 128'd0);
      @(negedge clk);
    end
    exp_mat = 128'h00000044_00000033_00000022_00000011;
    chk("mld_matrix", wb_matrix_o, exp_mat);
    chk("mld_rd", wb_rd, 128'd4);
    chk("mld_rw", wb_reg_write, 128'd1);
    clear_inputs();
    mem_valid = 1'b1; mem_alu_o = 32'h0000_0ABC; mem_rd = 5'd7; mem_reg_write = 1'b1;
    #1;
    chk("add_stall", mem_stall, 128'd0);
    @(posedge clk); #1;
    chk("add_wb_valid", wb_valid, 128'd1);
    chk("add_wb_rd", wb_rd, 128'd7);
    chk("add_wb_alu", wb_alu_o, 128'h0ABC);
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    chk("post_add_wb_valid", wb_valid, 128'd0);

    // Matrix store at 0x200 with mat_load also set: store wins, no read captured
    pat = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    @(negedge clk);
    mem_valid = 1'b1; mem_mat_store = 1'b1; mem_mat_load = 1'b1; mem_mem_write = 1'b1;
    mem_alu_o = 32'h200; mem_matrix_i = pat; mem_reg_write = 1'b1; mem_rd = 5'd6;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        mem_matrix_i = 128'd0; mem_alu_o = 32'd0; mem_mat_store = 1'b0;
      end
      #1;
      chk($sformatf("mst%0d_we", k), dmem_we, 128'd1);
      chk($sformatf("mst%0d_addr", k), dmem_addr, 128'h80 + 128'(k));
      chk($sformatf("mst%0d_wdata", k), dmem_wdata, 128'(pat[32*k +: 32]));
      chk($sformatf("mst%0d_stall", k), mem_stall, (k < 3) ? 128'd1 : 128'd0);
      @(posedge clk); #1;
      chk($sformatf("mst%0d_wb_valid", k), wb_valid, (k == 3) ? 128'd1 : 128'd0);
      chk($sformatf("mst%0d_wb_rw", k), wb_reg_write, 128'd0);
      @(negedge clk);
    end
    clear_inputs();
    chk("mst_matrix_hold", wb_matrix_o, 128'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("mst_mem%0d", k), mem[10'h080 + 10'(k)], 128'(pat[32*k +: 32]));

    // Reset during matrix store beat 2 at 0x300
    @(negedge clk);
    mem_valid = 1'b1; mem_mat_store = 1'b1; mem_alu_o = 32'h300;
    mem_matrix_i = 128'h44444444_33333333_22222222_11111111;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("rst2_pre_stall", mem_stall, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_stall", mem_stall, 128'd0);
    chk("rst2_we", dmem_we, 128'd0);
    chk("rst2_wb_valid", wb_valid, 128'd0);
    chk("rst2_wb_alu", wb_alu_o, 128'd0);
    chk("rst2_wb_rd", wb_rd, 128'd0);
    chk("rst2_wb_matrix", wb_matrix_o, 128'd0);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_mem0", mem[10'h0C0], 128'h11111111);
    chk("rst2_mem1", mem[10'h0C1], 128'h22222222);
    chk("rst2_mem2", mem[10'h0C2], 128'hFFFFFFFF);
    chk("rst2_mem3", mem[10'h0C3], 128'hFFFFFFFF);
    mem_valid = 1'b1; mem_mem_read = 1'b1; mem_mem2reg = 1'b1; mem_reg_write = 1'b1;
    mem_alu_o = 32'h100; mem_rd = 5'd2;
    #1;
    chk("rst2_idle_stall", mem_stall, 128'd0);
    chk("rst2_idle_addr", dmem_addr, 128'h40);
    @(posedge clk); #1;
    chk("rst2_idle_wb_valid", wb_valid, 128'd1);
    chk("rst2_idle_wb_data", wb_mem_data, 128'h11);
    @(negedge clk);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL provide parameter DMEM_AW, default 10, word-address width of the data memory port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_valid  input  1  instruction present from EX.
REQ-005 SHALL have port mem_alu_o  input  32  ALU result / byte address.
REQ-006 SHALL have port mem_rs2_data  input  32  scalar store data.
REQ-007 SHALL have port mem_matrix_i  input  128  matrix store data / matrix ALU result.
REQ-008 SHALL have ports mem_mem_read, mem_mem_write, mem_mat_load, mem_mat_store, mem_mem2reg, mem_reg_write  input  1 each  control.
REQ-009 SHALL have port mem_rd  input  5  destination register.
REQ-010 SHALL have port mem_stall  output  1  hold EX/MEM inputs stable.
REQ-011 SHALL have ports dmem_addr  output  DMEM_AW; dmem_wdata  output  32; dmem_we  output  1; dmem_rdata  input  32 (combinational read, write on clk edge).
REQ-012 SHALL have registered outputs wb_mem_data 32, wb_alu_o 32, wb_matrix_o 128, wb_mem2reg 1, wb_reg_write 1, wb_rd 5, wb_valid 1.

Function
REQ-013 SHALL implement FSM states IDLE, MLD (matrix load), MST (matrix store) with 2-bit beat counter.
REQ-014 dmem_addr SHALL be byte address bits [DMEM_AW+1:2] plus beat index; low two address bits ignored, no misalignment trap.
REQ-015 IDLE, mem_valid=0: wb_valid=0, wb_reg_write=0 next cycle; other wb_* data hold.
REQ-016 IDLE, scalar op (no mat flag): retire in one cycle; dmem_we=mem_mem_write, dmem_wdata=mem_rs2_data; next edge wb_mem_data=dmem_rdata, wb_alu_o=mem_alu_o, wb_matrix_o=mem_matrix_i, wb_mem2reg, wb_reg_write, wb_rd copied, wb_valid=1; mem_stall=0.
REQ-017 IDLE, mem_mat_load=1: beat 0 read this cycle, buf[31:0]<=dmem_rdata, latch base address, rd, controls; go MLD, beat=1; mem_stall=1 combinationally this cycle.
REQ-018 MLD beat k (1..3): read base+k, buf[32k+31:32k]<=dmem_rdata; mem_stall=1 for k=1,2, 0 for k=3.
REQ-019 MLD beat 3 edge: wb_matrix_o={dmem_rdata, buf[95:0]}, wb_valid=1, wb_reg_write/wb_rd/wb_mem2reg from latched controls, state IDLE.
REQ-020 IDLE, mem_mat_store=1: latch mem_matrix_i, write word 0 (bits [31:0]) at base this cycle; MST beats 1..3 write bits [32k+31:32k] at base+k; stall rule as REQ-018.
REQ-021 MST completion SHALL present wb_valid=1, wb_reg_write=0.
REQ-022 Cycles of MLD/MST except final beat SHALL drive wb_valid=0, wb_reg_write=0 (bubble).
REQ-023 Matrix op latency SHALL be exactly 4 cycles; scalar 1 cycle; back-to-back matrix ops SHALL start the cycle after final beat.
REQ-024 Inputs SHALL be ignored in MLD/MST; only latched copies used.
REQ-025 mem_mat_store and mem_mat_load both set: store SHALL win; mat flag with mem_mem_write: matrix path wins.
REQ-026 dmem_we SHALL be 0 in IDLE with mem_valid=0 and in MLD.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, beat 0, all wb_* outputs 0, buffers 0, mem_stall 0, dmem_we 0.
REQ-028 Reset mid MLD/MST SHALL abort without retire; partial matrix store words already written remain.

Verification
REQ-029 Scalar load: mem_alu_o=0x40, mem_mem_read=1, mem2reg=1, rd=5, memory[0x10]=0xDEADBEEF -> next cycle wb_mem_data=0xDEADBEEF, wb_rd=5, wb_valid=1, mem_stall 0.
REQ-030 Matrix load at 0x100, words 0x11,0x22,0x33,0x44 -> mem_stall high 3 cycles, 4th edge wb_matrix_o=0x00000044_00000033_00000022_00000011, wb_valid pulses once.
REQ-031 Matrix store 0xAAAA...0003_0002_0001_0000 pattern at 0x200 -> dmem_we 4 consecutive cycles, addr 0x80..0x83, wb_reg_write=0.
REQ-032 Back-to-back matrix load then scalar add (rd=7) -> add retires cycle 5, no lost/duplicated wb_valid.
REQ-033 rst_n asserted during MST beat 2 -> outputs 0 asynchronously, words 0-1 written, word 2-3 not, IDLE after release.
REQ-034 Both mat_load and mat_store set -> store behaviour, no read beats captured.
